// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit common-anode 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;

  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [AN_W-1:0]   an_t;
  typedef logic [CODE_W-1:0] code_t;

  // Per-digit payload routed from the selected input slot
  typedef struct packed {
    code_t code;
    logic  blank;
    logic  flash;
    logic  lz_dark;
  } digit_sel_t;

  localparam seg_t SEG_OFF = 7'h7F;
  localparam an_t  AN_OFF  = 4'hF;

  localparam code_t CODE_A = 4'd10;
  localparam code_t CODE_B = 4'd11;
  localparam code_t CODE_C = 4'd12;
  localparam code_t CODE_D = 4'd13;
  localparam code_t CODE_E = 4'd14;
  localparam code_t CODE_F = 4'd15;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex code to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg_c
);

  always_comb begin
    o_seg_c = SEG_OFF;
    case (i_code)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      CODE_A:  o_seg_c = SEG_A;
      CODE_B:  o_seg_c = SEG_B;
      CODE_C:  o_seg_c = SEG_C;
      CODE_D:  o_seg_c = SEG_D;
      CODE_E:  o_seg_c = SEG_E;
      CODE_F:  o_seg_c = SEG_F;
      default: o_seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blank/flash masks.
// Optional leading-zero suppression on digits 3..1 via SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] digit0,
  input  logic [CODE_W-1:0] digit1,
  input  logic [CODE_W-1:0] digit2,
  input  logic [CODE_W-1:0] digit3,
  input  logic [AN_W-1:0]   blank,
  input  logic [AN_W-1:0]   flash,
  output logic [SEG_W-1:0]  seg,
  output logic [AN_W-1:0]   an,
  output logic              dp
);

  localparam int unsigned PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [AN_W-1:0]    r_an;
  logic [SEG_W-1:0]   r_seg;

  logic               w_tick;
  logic               w_blink_wrap;
  logic [AN_W-1:0]    w_lz;
  digit_sel_t         w_sel;
  logic [SEG_W-1:0]   w_seg_dec;
  logic               w_dark;
  logic [AN_W-1:0]    w_an_on;

  assign w_tick       = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_blink_wrap = w_tick && (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1));

  // Prescaler, scan index and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        r_idx       <= r_idx + IDX_W'(1);
        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
        if (w_blink_wrap) r_phase <= ~r_phase;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is suppressed only when it and every digit to its left are zero
  always_comb begin
    w_lz    = '0;
    w_lz[3] = (digit3 == '0);
    w_lz[2] = w_lz[3] && (digit2 == '0);
    w_lz[1] = w_lz[2] && (digit1 == '0);
    w_lz[0] = 1'b0;
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    w_sel         = '0;
    w_sel.blank   = blank[r_idx];
    w_sel.flash   = flash[r_idx];
    w_sel.lz_dark = w_lz[r_idx];
    case (r_idx)
      2'd0:    w_sel.code = digit0;
      2'd1:    w_sel.code = digit1;
      2'd2:    w_sel.code = digit2;
      default: w_sel.code = digit3;
    endcase
  end

  seg7_decode u_decode (
    .i_code  (w_sel.code),
    .o_seg_c (w_seg_dec)
  );

  assign w_dark  = w_sel.blank || w_sel.lz_dark || (w_sel.flash && !r_phase);
  assign w_an_on = ~(AN_W'(1) << r_idx);

  // Output register reloads every cycle from live inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_dark ? AN_OFF  : w_an_on;
      r_seg <= w_dark ? SEG_OFF : w_seg_dec;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a cycle-count reference model.
module tb_seg7_scan_driver;

  localparam int unsigned SD = 4;
  localparam int unsigned BT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank, flash;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk    (clk),
    .rst    (rst),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .blank  (blank),
    .flash  (flash),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the tt-th clock edge since reset release
  function automatic void model(input int tt, output logic [3:0] ean, output logic [6:0] eseg);
    logic [3:0] d [4];
    int         slot;
    bit         visible_phase;
    bit         dark;
    d[0] = digit0; d[1] = digit1; d[2] = digit2; d[3] = digit3;
    slot          = ((tt - 1) / SD) % 4;
    visible_phase = (((tt - 1) / (SD * BT)) % 2) == 0;
    dark          = blank[slot] || (flash[slot] && !visible_phase);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot > 0) begin
      bit all_zero = 1'b1;
      for (int j = slot; j < 4; j++) if (d[j] != 4'd0) all_zero = 1'b0;
      if (all_zero) dark = 1'b1;
    end
`endif
    if (dark) begin
      ean  = 4'hF;
      eseg = 7'h7F;
    end else begin
      ean  = 4'hF ^ (4'h1 << slot);
      eseg = pat[d[slot]];
    end
  endfunction

  task automatic step(input string tag);
    logic [3:0] ean;
    logic [6:0] eseg;
    if (rst) begin
      ean  = 4'hF;
      eseg = 7'h7F;
    end else begin
      model(t + 1, ean, eseg);
    end
    @(posedge clk);
    #1;
    check_val({tag, "_an"}, 32'(an), 32'(ean));
    check_val({tag, "_seg"}, 32'(seg), 32'(eseg));
    check_val({tag, "_dp"}, 32'(dp), 32'd1);
    t = rst ? 0 : t + 1;
  endtask

  initial begin
    rst = 1'b1;
    {digit3, digit2, digit1, digit0} = 16'h0000;
    blank = 4'h0;
    flash = 4'h0;
    repeat (3) step("reset");

    // Basic rotation with digits 3,2,1,0
    rst = 1'b0;
    {digit3, digit2, digit1, digit0} = 16'h3210;
    step("first");
    check_val("first_an_dir", 32'(an), 32'h0000_000E);
    check_val("first_seg_dir", 32'(seg), 32'h0000_0040);
    repeat (3) step("slot0");
    step("slot1");
    check_val("slot1_an_dir", 32'(an), 32'h0000_000D);
    check_val("slot1_seg_dir", 32'(seg), 32'h0000_0079);
    repeat (35) step("rotate");

    // Letter codes on digit0
    for (int c = 10; c < 16; c++) begin
      digit0 = 4'(c);
      repeat (16) step("letter");
    end

    // Blank overrides flash on slot 2
    digit0 = 4'd8;
    blank  = 4'b0100;
    flash  = 4'b0100;
    repeat (32) step("blank_flash");

    // Flash on digit0 across both blink phases
    blank = 4'b0000;
    flash = 4'b0001;
    repeat (64) step("flash0");
    flash = 4'b0000;

    // Reset asserted during slot 2
    for (int k = 0; k < 20; k++) begin
      if ((((t - 1) / SD) % 4) == 2) break;
      step("seek2");
    end
    check_val("in_slot2", 32'(an), 32'h0000_000B);
    rst = 1'b1;
    step("midrst");
    check_val("midrst_an_dir", 32'(an), 32'h0000_000F);
    rst = 1'b0;
    step("restart");
    check_val("restart_an_dir", 32'(an), 32'h0000_000E);
    repeat (15) step("restart_run");

    // Leading-zero pattern (only suppressed when the option is built in)
    {digit3, digit2, digit1, digit0} = 16'h0050;
    repeat (32) step("lz");

    // Randomized inputs, changed between cycles
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        digit0 = 4'($urandom);
        digit1 = 4'($urandom);
        digit2 = 4'($urandom);
        digit3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 15) == 0) flash = 4'($urandom);
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      step("rand");
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
